ps2_host_cmd_ctrl: RTL and testbench

Host-side controller that sequences the PS/2 receive path and a host-to-device transmit shifter over the shared clock/data lines. It owns bus direction: it accepts one command byte from the system and inhibits the device clock. It then issues request-to-send, hands the byte to the transmit shifter and waits for the device response. It retries automatically when the device answers RESEND (0xFE). It sits between the system command/response interface and the PS/2 rx FSM / tx shifter, and gates the rx FSM through tx_idle.

---
 rtl/ps2_host_cmd_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_cmd_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host command controller: inhibit, request-to-send, hand-off to the tx shifter,
// then collect the device reply, re-sending automatically on RESEND (0xFE).
module ps2_host_cmd_ctrl #(
  parameter int INHIBIT_CYC      = 5000,
  parameter int RTS_CYC          = 50,
  parameter int SEND_TIMEOUT_CYC = 100000,
  parameter int RESP_TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY        = 3,
  parameter int TMR_W            = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       rx_busy,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       tx_idle,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       ps2_c_oe,
  output logic       ps2_d_oe,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_solicited,
  output logic       err_timeout,
  output logic       err_resend,
  output logic       busy
);

  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  // Timer compares against "last cycle in state" so each phase lasts exactly *_CYC cycles.
  localparam logic [TMR_W-1:0] INH_LAST  = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] RTS_LAST  = TMR_W'(RTS_CYC - 1);
  localparam logic [TMR_W-1:0] SEND_LAST = TMR_W'(SEND_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] RESP_LAST = TMR_W'(RESP_TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [7:0]       RESEND_B  = 8'hFE;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_WAIT_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       resp_data_q, resp_data_d;
  logic             resp_sol_q, resp_sol_d;
  logic             resp_valid_q, resp_valid_d;
  logic             tx_start_q, tx_start_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_resend_q, err_resend_d;
  logic             cmd_ready_q, cmd_ready_d;

  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    tx_data_d     = tx_data_q;
    resp_data_d   = resp_data_q;
    resp_sol_d    = resp_sol_q;
    resp_valid_d  = 1'b0;
    tx_start_d    = 1'b0;
    err_timeout_d = 1'b0;
    err_resend_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_done) begin
          resp_valid_d = 1'b1;
          resp_sol_d   = 1'b0;
          resp_data_d  = rx_data;
        end
        if (cmd_valid && cmd_ready_q) begin
          tx_data_d = cmd_data;
          retry_d   = '0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_q == INH_LAST) state_d = S_RTS;
      end
      S_RTS: begin
        if (timer_q == RTS_LAST) begin
          state_d    = S_SEND;
          tx_start_d = 1'b1;
        end
      end
      S_SEND: begin
        if (tx_done) begin
          state_d = S_WAIT_RESP;
        end else if (timer_q == SEND_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_WAIT_RESP: begin
        // A byte arriving on the timeout cycle still counts as the reply.
        if (rx_done) begin
          if (rx_data == RESEND_B) begin
            if (retry_q < RTY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = S_INHIBIT;
            end else begin
              err_resend_d = 1'b1;
              state_d      = S_IDLE;
            end
          end else begin
            resp_valid_d = 1'b1;
            resp_sol_d   = 1'b1;
            resp_data_d  = rx_data;
            state_d      = S_IDLE;
          end
        end else if (timer_q == RESP_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    timer_d     = (state_d != state_q) ? '0 : timer_inc;
    cmd_ready_d = (state_d == S_IDLE) && !rx_busy;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      retry_q       <= '0;
      tx_data_q     <= '0;
      resp_data_q   <= '0;
      resp_sol_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      tx_start_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_resend_q  <= 1'b0;
      cmd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      tx_data_q     <= tx_data_d;
      resp_data_q   <= resp_data_d;
      resp_sol_q    <= resp_sol_d;
      resp_valid_q  <= resp_valid_d;
      tx_start_q    <= tx_start_d;
      err_timeout_q <= err_timeout_d;
      err_resend_q  <= err_resend_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  // Bus-direction outputs decode straight from the state register so reset releases them at once.
  assign tx_idle        = (state_q == S_IDLE) || (state_q == S_WAIT_RESP);
  assign ps2_c_oe       = (state_q == S_INHIBIT) || (state_q == S_RTS);
  assign ps2_d_oe       = (state_q == S_RTS);
  assign busy           = (state_q != S_IDLE);
  assign cmd_ready      = cmd_ready_q;
  assign tx_start       = tx_start_q;
  assign tx_data        = tx_data_q;
  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign resp_solicited = resp_sol_q;
  assign err_timeout    = err_timeout_q;
  assign err_resend     = err_resend_q;

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Bench for ps2_host_cmd_ctrl: a device model drives random command exchanges while
// monitors check response/error pulses and each transmit hand-off against queued expectations.
module tb_ps2_host_cmd_ctrl;

  localparam int INHIBIT_CYC      = 12;
  localparam int RTS_CYC          = 4;
  localparam int SEND_TIMEOUT_CYC = 40;
  localparam int RESP_TIMEOUT_CYC = 60;
  localparam int MAX_RETRY        = 3;
  localparam int TMR_W            = 8;

  localparam int EV_RESP    = 0;
  localparam int EV_SEND_TO = 1;
  localparam int EV_RESP_TO = 2;
  localparam int EV_RESEND  = 3;

  localparam int MODE_REPLY   = 0;
  localparam int MODE_SEND_TO = 1;
  localparam int MODE_RESP_TO = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       sol;
  } event_t;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       rx_busy;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_idle;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       ps2_c_oe;
  logic       ps2_d_oe;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_solicited;
  logic       err_timeout;
  logic       err_resend;
  logic       busy;

  event_t     ev_q[$];
  logic [7:0] tx_q[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         cyc        = 0;

  ps2_host_cmd_ctrl #(
    .INHIBIT_CYC      (INHIBIT_CYC),
    .RTS_CYC          (RTS_CYC),
    .SEND_TIMEOUT_CYC (SEND_TIMEOUT_CYC),
    .RESP_TIMEOUT_CYC (RESP_TIMEOUT_CYC),
    .MAX_RETRY        (MAX_RETRY),
    .TMR_W            (TMR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_data       (cmd_data),
    .cmd_ready      (cmd_ready),
    .rx_busy        (rx_busy),
    .rx_done        (rx_done),
    .rx_data        (rx_data),
    .tx_idle        (tx_idle),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .tx_done        (tx_done),
    .ps2_c_oe       (ps2_c_oe),
    .ps2_d_oe       (ps2_d_oe),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_solicited (resp_solicited),
    .err_timeout    (err_timeout),
    .err_resend     (err_resend),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushEvent(input int kind, input logic [7:0] data, input logic sol);
    event_t e;
    e.kind = kind;
    e.data = data;
    e.sol  = sol;
    ev_q.push_back(e);
  endtask

  // Monitor: phase lengths, tx hand-off and every response/error pulse, checked at the falling edge.
  initial begin
    int     inh_cnt, rts_cnt, inh_len, rts_len, last_start_cyc, last_done_cyc, dt;
    event_t e;
    bit     ok;
    logic [7:0] exp_tx;
    inh_cnt = 0; rts_cnt = 0; inh_len = -1; rts_len = -1;
    last_start_cyc = 0; last_done_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        inh_cnt = 0;
        rts_cnt = 0;
      end else begin
        if (ps2_c_oe && ps2_d_oe) begin
          if (inh_cnt > 0) inh_len = inh_cnt;
          inh_cnt = 0;
          rts_cnt++;
        end else if (ps2_c_oe) begin
          inh_cnt++;
        end else begin
          if (rts_cnt > 0) rts_len = rts_cnt;
          rts_cnt = 0;
          inh_cnt = 0;
        end

        if (tx_start) begin
          compared++;
          if (tx_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL tx_start_unexpected: got tx_data=%h, required no tx_start", tx_data);
          end else begin
            exp_tx = tx_q.pop_front();
            ok = (tx_data == exp_tx) && (inh_len == INHIBIT_CYC) && (rts_len == RTS_CYC)
                 && !ps2_c_oe && !ps2_d_oe && !tx_idle;
            if (!ok) begin
              mismatched++;
              $display("[TB] FAIL tx_handoff: got data=%h inhibit=%0d rts=%0d oe=%b%b tx_idle=%b, required data=%h inhibit=%0d rts=%0d oe=00 tx_idle=0",
                       tx_data, inh_len, rts_len, ps2_c_oe, ps2_d_oe, tx_idle,
                       exp_tx, INHIBIT_CYC, RTS_CYC);
            end
          end
          inh_len = -1;
          rts_len = -1;
          last_start_cyc = cyc;
        end

        if (tx_done) last_done_cyc = cyc;

        if (resp_valid || err_timeout || err_resend) begin
          compared++;
          if (ev_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL event_unexpected: got resp_valid=%b data=%h sol=%b err_timeout=%b err_resend=%b, required no pulse",
                     resp_valid, resp_data, resp_solicited, err_timeout, err_resend);
          end else begin
            e  = ev_q.pop_front();
            dt = 0;
            case (e.kind)
              EV_RESP: ok = resp_valid && !err_timeout && !err_resend
                            && (resp_data == e.data) && (resp_solicited == e.sol);
              EV_RESEND: ok = err_resend && !resp_valid && !err_timeout;
              EV_SEND_TO: begin
                dt = cyc - last_start_cyc;
                ok = err_timeout && !resp_valid && !err_resend && (dt == SEND_TIMEOUT_CYC)
                     && !ps2_c_oe && !ps2_d_oe;
              end
              default: begin
                dt = cyc - last_done_cyc;
                ok = err_timeout && !resp_valid && !err_resend && (dt == RESP_TIMEOUT_CYC + 1);
              end
            endcase
            if (!ok) begin
              mismatched++;
              $display("[TB] FAIL event_kind%0d: got resp_valid=%b data=%h sol=%b err_timeout=%b err_resend=%b dt=%0d, required data=%h sol=%b",
                       e.kind, resp_valid, resp_data, resp_solicited, err_timeout, err_resend,
                       dt, e.data, e.sol);
            end
          end
        end
      end
    end
  end

  task automatic pulseRx(input logic [7:0] b);
    tick();
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic pulseTxDone();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic failBound(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got bound expired, required DUT event", name);
  endtask

  task automatic waitTxStart(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < INHIBIT_CYC + RTS_CYC + 20; i++) begin
      tick();
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failBound("wait_tx_start");
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < SEND_TIMEOUT_CYC + RESP_TIMEOUT_CYC + 50; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) failBound("wait_idle");
  endtask

  task automatic acceptCmd(input logic [7:0] cmd, input bit rx_with, input logic [7:0] rx_b);
    bit got;
    got = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        if (rx_with) begin
          rx_data = rx_b;
          rx_done = 1'b1;
        end
        tick();
        got = 1'b1;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    rx_done   = 1'b0;
    if (!got) failBound("accept_cmd");
  endtask

  // One command exchange; the expected outcome comes from the retry/timeout rules, not from the DUT.
  task automatic applyStimulus(input logic [7:0] cmd, input int n_fe, input int mode,
                               input logic [7:0] final_b, input bit hold_busy,
                               input bit rx_at_accept, input bit rx_in_inhibit);
    int         sends;
    bit         ok;
    logic [7:0] unsol_b;
    unsol_b = 8'($urandom);
    if (rx_at_accept && !hold_busy) pushEvent(EV_RESP, unsol_b, 1'b0);
    if (mode == MODE_SEND_TO) begin
      sends = 1;
      pushEvent(EV_SEND_TO, 8'h00, 1'b0);
    end else if (mode == MODE_RESP_TO) begin
      sends = 1;
      pushEvent(EV_RESP_TO, 8'h00, 1'b0);
    end else if (n_fe > MAX_RETRY) begin
      sends = MAX_RETRY + 1;
      pushEvent(EV_RESEND, 8'h00, 1'b0);
    end else begin
      sends = n_fe + 1;
      pushEvent(EV_RESP, final_b, 1'b1);
    end
    for (int i = 0; i < sends; i++) tx_q.push_back(cmd);

    if (hold_busy) begin
      rx_busy = 1'b1;
      tick();
      cmd_valid = 1'b1;
      cmd_data  = cmd;
      repeat (3) begin
        tick();
        checkOutput("cmd_ready_while_rx_busy", cmd_ready, 0);
      end
      rx_busy = 1'b0;
      checkOutput("cmd_ready_at_rx_busy_fall", cmd_ready, 0);
      tick();
      checkOutput("cmd_ready_after_rx_busy_fall", cmd_ready, 1);
      checkOutput("busy_before_accept", busy, 0);
      tick();
      checkOutput("busy_after_accept", busy, 1);
      cmd_valid = 1'b0;
    end else begin
      acceptCmd(cmd, rx_at_accept, unsol_b);
    end

    if (rx_in_inhibit) begin
      tick();
      tick();
      checkOutput("c_oe_before_ignored_rx", ps2_c_oe, 1);
      pulseRx(8'($urandom));
    end

    for (int i = 0; i < sends; i++) begin
      waitTxStart(ok);
      if (!ok) break;
      if (mode == MODE_SEND_TO) break;
      repeat ($urandom_range(0, 6)) tick();
      pulseTxDone();
      if (mode == MODE_RESP_TO) break;
      repeat ($urandom_range(0, 6)) tick();
      pulseRx((i < n_fe) ? 8'hFE : final_b);
    end
    waitIdle();
    repeat (3) tick();
  endtask

  task automatic sendUnsolicited(input logic [7:0] b);
    pushEvent(EV_RESP, b, 1'b0);
    pulseRx(b);
    repeat (2) tick();
  endtask

  initial begin
    logic [7:0] c, f;
    int         n;
    bit         hb, ra, ri;

    rst = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00; rx_busy = 1'b0;
    rx_done = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
    #12;
    checkOutput("reset_tx_idle", tx_idle, 1);
    checkOutput("reset_cmd_ready", cmd_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_oe", {ps2_c_oe, ps2_d_oe}, 0);
    checkOutput("reset_pulses", {resp_valid, err_timeout, err_resend, tx_start}, 0);
    checkOutput("reset_tx_data", tx_data, 0);
    checkOutput("reset_resp_data", resp_data, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("cmd_ready_after_first_clock", cmd_ready, 1);

    $display("[TB] directed exchanges");
    applyStimulus(8'hFF, 0, MODE_REPLY, 8'hFA, 1'b0, 1'b0, 1'b0);
    checkOutput("busy_after_basic", busy, 0);
    applyStimulus(8'hED, 3, MODE_REPLY, 8'hFA, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hED, 4, MODE_REPLY, 8'hFA, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hF4, 0, MODE_SEND_TO, 8'hFA, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hF2, 0, MODE_RESP_TO, 8'hFA, 1'b0, 1'b0, 1'b0);
    sendUnsolicited(8'hAA);
    applyStimulus(8'hF3, 0, MODE_REPLY, 8'hFA, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hF5, 1, MODE_REPLY, 8'h12, 1'b0, 1'b1, 1'b1);

    $display("[TB] reset during inhibit");
    acceptCmd(8'h55, 1'b0, 8'h00);
    repeat (4) tick();
    checkOutput("c_oe_before_reset", ps2_c_oe, 1);
    #3 rst = 1'b0;
    #1;
    checkOutput("reset_mid_c_oe", ps2_c_oe, 0);
    checkOutput("reset_mid_d_oe", ps2_d_oe, 0);
    checkOutput("reset_mid_busy", busy, 0);
    checkOutput("reset_mid_tx_idle", tx_idle, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (INHIBIT_CYC + RTS_CYC + 10) tick();
    checkOutput("busy_after_reset_release", busy, 0);

    $display("[TB] random exchanges");
    for (int k = 0; k < 12; k++) begin
      c  = 8'($urandom);
      n  = $urandom_range(0, 4);
      do f = 8'($urandom); while (f == 8'hFE);
      hb = ($urandom_range(0, 3) == 0);
      ra = ($urandom_range(0, 3) == 0);
      ri = ($urandom_range(0, 2) == 0);
      applyStimulus(c, n, MODE_REPLY, f, hb, ra, ri);
      if ($urandom_range(0, 2) == 0) sendUnsolicited(8'($urandom));
    end

    repeat (5) tick();
    checkOutput("events_drained", ev_q.size(), 0);
    checkOutput("tx_handoffs_drained", tx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
